// File: rtl/pr_ex_mem_if.sv
// EX/MEM pipeline register bus: EX-side inputs, MEM-side outputs, stall/flush control.
interface pr_ex_mem_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic            flush;

    logic [XLEN-1:0] pc_ex_i;
    logic [XLEN-1:0] pc4_ex_i;
    logic            instr_valid_ex_i;
    logic [XLEN-1:0] alu_result_ex_i;
    logic [XLEN-1:0] store_data_ex_i;
    logic            dram_we_ex_i;
    logic            rf_we_ex_i;
    logic [1:0]      wd_sel_ex_i;
    logic [4:0]      wr_ex_i;
    logic [3:0]      sl_type_ex_i;

    logic [XLEN-1:0] pc_mem_o;
    logic [XLEN-1:0] pc4_mem_o;
    logic            instr_valid_mem_o;
    logic [XLEN-1:0] alu_result_mem_o;
    logic [XLEN-1:0] dram_addr_o;
    logic [XLEN-1:0] dram_wdata_o;
    logic [3:0]      dram_be_o;
    logic            dram_we_mem_o;
    logic            rf_we_mem_o;
    logic [1:0]      wd_sel_mem_o;
    logic [4:0]      wr_mem_o;
    logic [3:0]      sl_type_mem_o;
    logic [1:0]      byte_off_mem_o;
    logic            misalign_mem_o;
    logic            fwd_valid_mem_o;
    logic [XLEN-1:0] fwd_data_mem_o;

    // Upstream side: drives EX values and pipeline control, observes MEM stage.
    modport master (
        output stall, flush,
        output pc_ex_i, pc4_ex_i, instr_valid_ex_i, alu_result_ex_i, store_data_ex_i,
        output dram_we_ex_i, rf_we_ex_i, wd_sel_ex_i, wr_ex_i, sl_type_ex_i,
        input  pc_mem_o, pc4_mem_o, instr_valid_mem_o, alu_result_mem_o, dram_addr_o,
        input  dram_wdata_o, dram_be_o, dram_we_mem_o, rf_we_mem_o, wd_sel_mem_o,
        input  wr_mem_o, sl_type_mem_o, byte_off_mem_o, misalign_mem_o,
        input  fwd_valid_mem_o, fwd_data_mem_o
    );

    // Pipeline register side.
    modport slave (
        input  stall, flush,
        input  pc_ex_i, pc4_ex_i, instr_valid_ex_i, alu_result_ex_i, store_data_ex_i,
        input  dram_we_ex_i, rf_we_ex_i, wd_sel_ex_i, wr_ex_i, sl_type_ex_i,
        output pc_mem_o, pc4_mem_o, instr_valid_mem_o, alu_result_mem_o, dram_addr_o,
        output dram_wdata_o, dram_be_o, dram_we_mem_o, rf_we_mem_o, wd_sel_mem_o,
        output wr_mem_o, sl_type_mem_o, byte_off_mem_o, misalign_mem_o,
        output fwd_valid_mem_o, fwd_data_mem_o
    );
endinterface

// File: rtl/pr_ex_mem.sv
// EX/MEM pipeline register with data-memory lane pre-computation,
// misalignment detection and MEM-stage forwarding source.
module pr_ex_mem #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    pr_ex_mem_if.slave  bus
);
    localparam logic [3:0] SL_LB  = 4'd1;
    localparam logic [3:0] SL_LBU = 4'd2;
    localparam logic [3:0] SL_LH  = 4'd3;
    localparam logic [3:0] SL_LHU = 4'd4;
    localparam logic [3:0] SL_LW  = 4'd5;
    localparam logic [3:0] SL_SB  = 4'd6;
    localparam logic [3:0] SL_SH  = 4'd7;
    localparam logic [3:0] SL_SW  = 4'd8;

    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;

    localparam logic [XLEN-1:0] BUBBLE_PC  = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] BUBBLE_PC4 = XLEN'(RESET_PC + 32'd4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            dram_we_q, dram_we_d;
    logic            rf_we_q, rf_we_d;
    logic [1:0]      wd_sel_q, wd_sel_d;
    logic [4:0]      wr_q, wr_d;
    logic [3:0]      sl_type_q, sl_type_d;
    logic            misalign_q, misalign_d;

    logic [1:0]      off;
    logic            is_byte;
    logic            is_half;
    logic            is_word;
    logic            mis;
    logic [3:0]      be_raw;
    logic [XLEN-1:0] wdata_raw;

    // Decode access size, byte lanes, store data replication and misalignment.
    always_comb begin
        off       = bus.alu_result_ex_i[1:0];
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        wdata_raw = '0;
        case (bus.sl_type_ex_i)
            SL_LB, SL_LBU, SL_SB: is_byte = 1'b1;
            SL_LH, SL_LHU, SL_SH: is_half = 1'b1;
            SL_LW, SL_SW:         is_word = 1'b1;
            default:              ;
        endcase
        case (bus.sl_type_ex_i)
            SL_SB:   wdata_raw = {4{bus.store_data_ex_i[7:0]}};
            SL_SH:   wdata_raw = {2{bus.store_data_ex_i[15:0]}};
            SL_SW:   wdata_raw = bus.store_data_ex_i;
            default: wdata_raw = '0;
        endcase
        if (is_byte) begin
            be_raw = 4'b0001 << off;
        end else if (is_half) begin
            be_raw = 4'b0011 << off;
        end else if (is_word) begin
            be_raw = 4'b1111;
        end else begin
            be_raw = 4'b0000;
        end
        mis = bus.instr_valid_ex_i & ((is_half & off[0]) | (is_word & (off != 2'd0)));
    end

    // Next-state: flush loads a bubble, stall holds, otherwise capture EX.
    always_comb begin
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        alu_d      = alu_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        dram_we_d  = dram_we_q;
        rf_we_d    = rf_we_q;
        wd_sel_d   = wd_sel_q;
        wr_d       = wr_q;
        sl_type_d  = sl_type_q;
        misalign_d = misalign_q;
        if (bus.flush) begin
            pc_d       = BUBBLE_PC;
            pc4_d      = BUBBLE_PC4;
            valid_d    = 1'b0;
            alu_d      = '0;
            wdata_d    = '0;
            be_d       = '0;
            dram_we_d  = 1'b0;
            rf_we_d    = 1'b0;
            wd_sel_d   = '0;
            wr_d       = '0;
            sl_type_d  = '0;
            misalign_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d       = bus.pc_ex_i;
            pc4_d      = bus.pc4_ex_i;
            valid_d    = bus.instr_valid_ex_i;
            alu_d      = bus.alu_result_ex_i;
            wdata_d    = wdata_raw;
            be_d       = mis ? 4'b0000 : be_raw;
            dram_we_d  = bus.dram_we_ex_i & bus.instr_valid_ex_i & ~mis;
            rf_we_d    = bus.rf_we_ex_i & bus.instr_valid_ex_i & ~mis;
            wd_sel_d   = bus.wd_sel_ex_i;
            wr_d       = bus.wr_ex_i;
            sl_type_d  = bus.sl_type_ex_i;
            misalign_d = mis;
        end
    end

    // State register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= BUBBLE_PC;
            pc4_q      <= BUBBLE_PC4;
            valid_q    <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            dram_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wd_sel_q   <= '0;
            wr_q       <= '0;
            sl_type_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            dram_we_q  <= dram_we_d;
            rf_we_q    <= rf_we_d;
            wd_sel_q   <= wd_sel_d;
            wr_q       <= wr_d;
            sl_type_q  <= sl_type_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_mem_o          = pc_q;
    assign bus.pc4_mem_o         = pc4_q;
    assign bus.instr_valid_mem_o = valid_q;
    assign bus.alu_result_mem_o  = alu_q;
    assign bus.dram_addr_o       = {alu_q[XLEN-1:2], 2'b00};
    assign bus.dram_wdata_o      = wdata_q;
    assign bus.dram_be_o         = be_q;
    assign bus.dram_we_mem_o     = dram_we_q;
    assign bus.rf_we_mem_o       = rf_we_q;
    assign bus.wd_sel_mem_o      = wd_sel_q;
    assign bus.wr_mem_o          = wr_q;
    assign bus.sl_type_mem_o     = sl_type_q;
    assign bus.byte_off_mem_o    = alu_q[1:0];
    assign bus.misalign_mem_o    = misalign_q;

    // Loads are excluded from forwarding; the hazard unit stalls on them.
    assign bus.fwd_valid_mem_o   = valid_q & rf_we_q & (wr_q != 5'd0) & (wd_sel_q != WD_DRAM);
    assign bus.fwd_data_mem_o    = (wd_sel_q == WD_PC4) ? pc4_q : alu_q;
endmodule

// File: tb/tb_pr_ex_mem.sv
// Self-checking bench for the EX/MEM pipeline register.
module tb_pr_ex_mem;
    logic clk;
    logic rst;

    pr_ex_mem_if bus ();

    pr_ex_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        dwe;
        logic        rfwe;
        logic [1:0]  wd_sel;
        logic [4:0]  wr;
        logic [3:0]  sl;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        dwe;
        logic        rwe;
        logic [1:0]  wd_sel;
        logic [4:0]  wr;
        logic [3:0]  sl;
        logic        mis;
    } mstate_t;

    typedef struct packed {
        stim_t       stim;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        mis;
        logic        dwe;
        logic        rwe;
        logic        valid;
        logic        fv;
        logic [31:0] fd;
    } vec_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    mstate_t model;
    vec_t    vecs [12];

    function automatic stim_t mk(logic valid, logic [31:0] pc, logic [31:0] pc4, logic [31:0] alu,
                                 logic [31:0] sd, logic dwe, logic rfwe, logic [1:0] wd_sel,
                                 logic [4:0] wr, logic [3:0] sl);
        stim_t s;
        s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0;
        s.pc = pc; s.pc4 = pc4; s.valid = valid; s.alu = alu; s.sd = sd;
        s.dwe = dwe; s.rfwe = rfwe; s.wd_sel = wd_sel; s.wr = wr; s.sl = sl;
        return s;
    endfunction

    function automatic vec_t mkv(stim_t s, logic [3:0] be, logic [31:0] wdata, logic [31:0] addr,
                                 logic mis, logic dwe, logic rwe, logic valid, logic fv,
                                 logic [31:0] fd);
        vec_t v;
        v.stim = s; v.be = be; v.wdata = wdata; v.addr = addr; v.mis = mis;
        v.dwe = dwe; v.rwe = rwe; v.valid = valid; v.fv = fv; v.fd = fd;
        return v;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst    = ($urandom_range(0, 49) == 0);
        s.flush  = ($urandom_range(0, 9) == 0);
        s.stall  = ($urandom_range(0, 4) == 0);
        s.pc     = $urandom;
        s.pc4    = s.pc + 32'd4;
        s.valid  = ($urandom_range(0, 5) != 0);
        s.alu    = $urandom;
        s.sd     = $urandom;
        s.dwe    = 1'($urandom);
        s.rfwe   = 1'($urandom);
        s.wd_sel = 2'($urandom);
        s.wr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        s.sl     = 4'($urandom);
        return s;
    endfunction

    function automatic mstate_t bubble();
        mstate_t m;
        m = '0;
        m.pc  = 32'h0;
        m.pc4 = 32'h4;
        return m;
    endfunction

    // Reference capture: access size in bytes, lanes from size and offset.
    function automatic mstate_t capture(stim_t s);
        mstate_t     m;
        int unsigned off;
        int unsigned size;
        off  = 32'(s.alu[1:0]);
        size = 0;
        if (s.sl == 4'd1 || s.sl == 4'd2 || s.sl == 4'd6) size = 1;
        if (s.sl == 4'd3 || s.sl == 4'd4 || s.sl == 4'd7) size = 2;
        if (s.sl == 4'd5 || s.sl == 4'd8) size = 4;
        m.pc     = s.pc;
        m.pc4    = s.pc4;
        m.valid  = s.valid;
        m.alu    = s.alu;
        m.wd_sel = s.wd_sel;
        m.wr     = s.wr;
        m.sl     = s.sl;
        m.mis    = s.valid && size > 1 && (off % size) != 0;
        if (size == 0)      m.be = 4'd0;
        else if (size == 4) m.be = 4'hF;
        else                m.be = 4'((((1 << size) - 1) << off) & 15);
        if (m.mis) m.be = 4'd0;
        if (s.sl == 4'd6)      m.wdata = 32'(s.sd[7:0]) * 32'h0101_0101;
        else if (s.sl == 4'd7) m.wdata = 32'(s.sd[15:0]) * 32'h0001_0001;
        else if (s.sl == 4'd8) m.wdata = s.sd;
        else                   m.wdata = 32'h0;
        m.dwe = s.dwe && s.valid && !m.mis;
        m.rwe = s.rfwe && s.valid && !m.mis;
        return m;
    endfunction

    function automatic mstate_t next_model(mstate_t cur, stim_t s);
        if (s.rst || s.flush) return bubble();
        if (s.stall) return cur;
        return capture(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        rst                  = s.rst;
        bus.stall            = s.stall;
        bus.flush            = s.flush;
        bus.pc_ex_i          = s.pc;
        bus.pc4_ex_i         = s.pc4;
        bus.instr_valid_ex_i = s.valid;
        bus.alu_result_ex_i  = s.alu;
        bus.store_data_ex_i  = s.sd;
        bus.dram_we_ex_i     = s.dwe;
        bus.rf_we_ex_i       = s.rfwe;
        bus.wd_sel_ex_i      = s.wd_sel;
        bus.wr_ex_i          = s.wr;
        bus.sl_type_ex_i     = s.sl;
    endtask

    task automatic step(input stim_t s);
        drive(s);
        @(posedge clk);
        #1;
        model = next_model(model, s);
    endtask

    task automatic compare_model(input string tag);
        logic fv;
        fv = model.valid && model.rwe && model.wr != 5'd0 && model.wd_sel != 2'd1;
        chk({tag, ".pc"},      bus.pc_mem_o, model.pc);
        chk({tag, ".pc4"},     bus.pc4_mem_o, model.pc4);
        chk({tag, ".valid"},   32'(bus.instr_valid_mem_o), 32'(model.valid));
        chk({tag, ".alu"},     bus.alu_result_mem_o, model.alu);
        chk({tag, ".addr"},    bus.dram_addr_o, model.alu & 32'hFFFF_FFFC);
        chk({tag, ".wdata"},   bus.dram_wdata_o, model.wdata);
        chk({tag, ".be"},      32'(bus.dram_be_o), 32'(model.be));
        chk({tag, ".dwe"},     32'(bus.dram_we_mem_o), 32'(model.dwe));
        chk({tag, ".rwe"},     32'(bus.rf_we_mem_o), 32'(model.rwe));
        chk({tag, ".wd_sel"},  32'(bus.wd_sel_mem_o), 32'(model.wd_sel));
        chk({tag, ".wr"},      32'(bus.wr_mem_o), 32'(model.wr));
        chk({tag, ".sl"},      32'(bus.sl_type_mem_o), 32'(model.sl));
        chk({tag, ".off"},     32'(bus.byte_off_mem_o), model.alu % 4);
        chk({tag, ".mis"},     32'(bus.misalign_mem_o), 32'(model.mis));
        chk({tag, ".fv"},      32'(bus.fwd_valid_mem_o), 32'(fv));
        chk({tag, ".fd"},      bus.fwd_data_mem_o, (model.wd_sel == 2'd2) ? model.pc4 : model.alu);
    endtask

    initial begin
        stim_t s;
        stim_t idle;

        // Directed vectors: inputs and hand-derived expected MEM outputs.
        vecs[0]  = mkv(mk(1, 32'h100, 32'h104, 32'h1003, 32'hAABBCCDD, 1, 0, 2'd0, 5'd0, 4'd6),
                       4'b1000, 32'hDDDDDDDD, 32'h1000, 0, 1, 0, 1, 0, 32'h1003);
        vecs[1]  = mkv(mk(1, 32'h104, 32'h108, 32'h2002, 32'h0, 0, 1, 2'd1, 5'd7, 4'd5),
                       4'b0000, 32'h0, 32'h2000, 1, 0, 0, 1, 0, 32'h2002);
        vecs[2]  = mkv(mk(1, 32'h104, 32'h108, 32'h40, 32'h0, 0, 1, 2'd2, 5'd1, 4'd0),
                       4'b0000, 32'h0, 32'h40, 0, 0, 1, 1, 1, 32'h108);
        vecs[3]  = mkv(mk(1, 32'h10C, 32'h110, 32'h3000, 32'h0, 0, 1, 2'd1, 5'd3, 4'd5),
                       4'b1111, 32'h0, 32'h3000, 0, 0, 1, 1, 0, 32'h3000);
        vecs[4]  = mkv(mk(1, 32'h110, 32'h114, 32'h2006, 32'h12345678, 1, 0, 2'd0, 5'd0, 4'd7),
                       4'b1100, 32'h56785678, 32'h2004, 0, 1, 0, 1, 0, 32'h2006);
        vecs[5]  = mkv(mk(1, 32'h114, 32'h118, 32'h11, 32'h0, 0, 1, 2'd1, 5'd4, 4'd3),
                       4'b0000, 32'h0, 32'h10, 1, 0, 0, 1, 0, 32'h11);
        vecs[6]  = mkv(mk(1, 32'h118, 32'h11C, 32'h22, 32'h0, 0, 1, 2'd1, 5'd9, 4'd2),
                       4'b0100, 32'h0, 32'h20, 0, 0, 1, 1, 0, 32'h22);
        vecs[7]  = mkv(mk(0, 32'h11C, 32'h120, 32'h40, 32'hCAFEBABE, 1, 1, 2'd0, 5'd2, 4'd8),
                       4'b1111, 32'hCAFEBABE, 32'h40, 0, 0, 0, 0, 0, 32'h40);
        vecs[8]  = mkv(mk(1, 32'h120, 32'h124, 32'hDEADBEEF, 32'h0, 0, 1, 2'd3, 5'd10, 4'd12),
                       4'b0000, 32'h0, 32'hDEADBEEC, 0, 0, 1, 1, 1, 32'hDEADBEEF);
        vecs[9]  = mkv(mk(1, 32'h124, 32'h128, 32'h77, 32'h0, 0, 1, 2'd0, 5'd0, 4'd0),
                       4'b0000, 32'h0, 32'h74, 0, 0, 1, 1, 0, 32'h77);
        vecs[10] = mkv(mk(1, 32'h128, 32'h12C, 32'h105, 32'h01020304, 1, 0, 2'd0, 5'd0, 4'd8),
                       4'b0000, 32'h01020304, 32'h104, 1, 0, 0, 1, 0, 32'h105);
        vecs[11] = mkv(mk(1, 32'h12C, 32'h130, 32'h8, 32'h0000009A, 1, 0, 2'd0, 5'd0, 4'd6),
                       4'b0001, 32'h9A9A9A9A, 32'h8, 0, 1, 0, 1, 0, 32'h8);

        idle = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 2'd0, 5'd0, 4'd0);
        model = bubble();

        // Reset held for two cycles, then released.
        s = idle; s.rst = 1'b1;
        step(s);
        step(s);
        chk("rst.valid", 32'(bus.instr_valid_mem_o), 32'h0);
        chk("rst.pc",    bus.pc_mem_o, 32'h0);
        chk("rst.pc4",   bus.pc4_mem_o, 32'h4);
        chk("rst.fv",    32'(bus.fwd_valid_mem_o), 32'h0);
        chk("rst.be",    32'(bus.dram_be_o), 32'h0);
        chk("rst.dwe",   32'(bus.dram_we_mem_o), 32'h0);
        compare_model("rst");

        // Table-driven directed vectors.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].stim);
            chk($sformatf("vec%0d.be", i),    32'(bus.dram_be_o), 32'(vecs[i].be));
            chk($sformatf("vec%0d.wdata", i), bus.dram_wdata_o, vecs[i].wdata);
            chk($sformatf("vec%0d.addr", i),  bus.dram_addr_o, vecs[i].addr);
            chk($sformatf("vec%0d.mis", i),   32'(bus.misalign_mem_o), 32'(vecs[i].mis));
            chk($sformatf("vec%0d.dwe", i),   32'(bus.dram_we_mem_o), 32'(vecs[i].dwe));
            chk($sformatf("vec%0d.rwe", i),   32'(bus.rf_we_mem_o), 32'(vecs[i].rwe));
            chk($sformatf("vec%0d.valid", i), 32'(bus.instr_valid_mem_o), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.fv", i),    32'(bus.fwd_valid_mem_o), 32'(vecs[i].fv));
            chk($sformatf("vec%0d.fd", i),    bus.fwd_data_mem_o, vecs[i].fd);
        end

        // ADD result held across a three-cycle stall with changing inputs.
        step(mk(1, 32'h200, 32'h204, 32'h55, 32'h0, 0, 1, 2'd0, 5'd5, 4'd0));
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
            step(s);
            chk($sformatf("stall%0d.alu", i), bus.alu_result_mem_o, 32'h55);
            chk($sformatf("stall%0d.wr", i),  32'(bus.wr_mem_o), 32'd5);
            chk($sformatf("stall%0d.fv", i),  32'(bus.fwd_valid_mem_o), 32'd1);
            chk($sformatf("stall%0d.fd", i),  bus.fwd_data_mem_o, 32'h55);
            chk($sformatf("stall%0d.pc", i),  bus.pc_mem_o, 32'h200);
        end

        // Flush together with stall and a valid SW: bubble wins.
        s = mk(1, 32'h300, 32'h304, 32'h400, 32'h11223344, 1, 0, 2'd0, 5'd6, 4'd8);
        s.flush = 1'b1; s.stall = 1'b1;
        step(s);
        chk("flush.valid", 32'(bus.instr_valid_mem_o), 32'h0);
        chk("flush.dwe",   32'(bus.dram_we_mem_o), 32'h0);
        chk("flush.wr",    32'(bus.wr_mem_o), 32'h0);
        chk("flush.pc4",   bus.pc4_mem_o, 32'h4);

        // Reset during a stall still loads a bubble.
        step(mk(1, 32'h500, 32'h504, 32'h9, 32'h0, 0, 1, 2'd0, 5'd8, 4'd0));
        s = idle; s.stall = 1'b1; s.rst = 1'b1;
        step(s);
        chk("rststall.valid", 32'(bus.instr_valid_mem_o), 32'h0);
        chk("rststall.wr",    32'(bus.wr_mem_o), 32'h0);
        chk("rststall.pc",    bus.pc_mem_o, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(rand_stim());
            compare_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pr_ex_mem.md
Name: pr_ex_mem

Overview:
- EX/MEM pipeline register, directly downstream of the ID/EX register and the EX-stage ALU.
- Captures the EX result and control, and pre-computes data-memory byte enables, aligned address and shifted store data.
- Detects misaligned accesses and produces a MEM-stage forwarding source for the EX operand muxes.
- Supports stall (hold) and flush (insert bubble).

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- RESET_PC, 32'h0000_0000, value loaded into pc_mem_o/pc4_mem_o on reset and flush.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold all MEM outputs this cycle
- flush  in  1  replace captured instruction with bubble
- pc_ex_i  in  32  EX PC
- pc4_ex_i  in  32  EX PC+4
- instr_valid_ex_i  in  1  EX instruction valid
- alu_result_ex_i  in  32  ALU result / effective address
- store_data_ex_i  in  32  forwarded rs2 value
- dram_we_ex_i  in  1  store request
- rf_we_ex_i  in  1  register write enable
- wd_sel_ex_i  in  2  writeback source: 0 ALU, 1 DRAM, 2 PC4, 3 reserved (treated as ALU)
- wr_ex_i  in  5  destination register
- sl_type_ex_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9–15 treated as none
- pc_mem_o, pc4_mem_o  out  32  registered PCs
- instr_valid_mem_o  out  1  MEM instruction valid
- alu_result_mem_o  out  32  registered ALU result
- dram_addr_o  out  32  {alu_result[31:2], 2'b00}
- dram_wdata_o  out  32  store data shifted into byte lanes
- dram_be_o  out  4  byte enables (loads and stores)
- dram_we_mem_o  out  1  qualified store strobe
- rf_we_mem_o  out  1  qualified register write
- wd_sel_mem_o  out  2  registered wd_sel
- wr_mem_o  out  5  registered destination
- sl_type_mem_o  out  4  registered sl_type
- byte_off_mem_o  out  2  alu_result[1:0], for the load extender
- misalign_mem_o  out  1  misaligned access flag
- fwd_valid_mem_o  out  1  MEM value forwardable to EX
- fwd_data_mem_o  out  32  forwarding value (comb from registered state)

Behaviour:
- Latency: one cycle. Inputs sampled at posedge and visible on the outputs after that edge.
- Priority per edge: rst > flush > stall > load.
- Reset and flush both load a bubble:
  - all control outputs 0 (valid, we's, misalign, be, wd_sel, wr, sl_type, byte_off);
  - data outputs 0;
  - pc_mem_o = RESET_PC, pc4_mem_o = RESET_PC + 4.
- Flush asserted together with stall: bubble is loaded (flush wins).
- Stall: every register holds its value; outputs are stable for the whole stall.
- Load: capture all inputs. If instr_valid_ex_i = 0, force dram_we and rf_we to 0; data fields are still captured.
- Byte enables (off = alu_result[1:0]):
  - byte: 4'b0001 << off;
  - half: 4'b0011 << off;
  - word: 4'b1111;
  - none: 4'b0000.
- Store data (off = alu_result[1:0]):
  - SB: data[7:0] replicated to all 4 lanes;
  - SH: data[15:0] replicated to both halves;
  - SW: unchanged;
  - loads and none: 0.
- Misalignment:
  - LH/LHU/SH with off[0] = 1, or LW/SW with off != 0, sets misalign_mem_o = 1 (only if valid).
  - On a misaligned access, dram_we_mem_o, rf_we_mem_o and dram_be_o are forced 0; valid stays 1 so the trap logic sees the PC.
- Forwarding:
  - fwd_valid_mem_o = valid & rf_we_mem_o & (wr_mem_o != 0) & (wd_sel_mem_o != 1).
  - Loads are not forwardable; the hazard unit stalls on them.
  - fwd_data_mem_o = pc4_mem_o if wd_sel_mem_o = 2, else alu_result_mem_o.
- wr = 0 with rf_we = 1: captured as-is, but fwd_valid_mem_o stays 0.
- Reset mid-stall: reset wins; the bubble appears on the next edge.

Test Plan:
- rst = 1 for 2 cycles, then deassert -> all control outputs 0, pc_mem_o = 0, pc4_mem_o = 4, fwd_valid_mem_o = 0.
- SB, alu_result = 0x1003, store_data = 0xAABBCCDD, valid -> next cycle dram_be_o = 4'b1000, dram_wdata_o = 0xDDDDDDDD, dram_addr_o = 0x1000, dram_we_mem_o = 1, misalign_mem_o = 0.
- LW, alu_result = 0x2002, valid, rf_we = 1 -> misalign_mem_o = 1, rf_we_mem_o = 0, dram_be_o = 0, instr_valid_mem_o = 1.
- ADD result 0x55, wr = 5, rf_we = 1, then stall for 3 cycles with different inputs -> outputs hold 0x55 and wr 5 all 3 cycles; fwd_valid_mem_o = 1, fwd_data_mem_o = 0x55.
- flush and stall both asserted with a valid SW on the inputs -> next cycle instr_valid_mem_o = 0, dram_we_mem_o = 0, wr_mem_o = 0.
- JAL: wd_sel = 2, pc4 = 0x108, wr = 1 -> fwd_data_mem_o = 0x108. LW with wd_sel = 1, aligned -> fwd_valid_mem_o = 0, dram_be_o = 4'b1111.
